// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper.
package truth_table_sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    // One MISR compaction step: shift left, fold in the polynomial when the
    // outgoing MSB differs from the incoming response bit.
    function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic din);
        logic [15:0] tap;
        tap = (sig[15] ^ din) ? MISR_POLY : 16'h0000;
        return {sig[14:0], 1'b0} ^ tap;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_tag_delay.sv
// Delay line that keeps the vector tag (index + valid) aligned with the
// response of the function instances. Depth 0 is a plain wire.
module tag_delay
    import truth_table_sweeper_pkg::*;
#(
    parameter int DEPTH = 0,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_s;
            assign unused_s = clk ^ rst ^ flush;
            assign q        = d;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_r [DEPTH];

            // Shift the tag one stage per cycle; flush empties all stages.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) stage_r[i] <= {WIDTH{1'b0}};
                end else if (flush) begin
                    for (int i = 0; i < DEPTH; i++) stage_r[i] <= {WIDTH{1'b0}};
                end else begin
                    stage_r[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
                end
            end

            assign q = stage_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive sweeper: drives every input vector to a golden and an
// implementation instance, compares responses, counts mismatches and ones,
// records the first failing vector and compacts dut_out into a MISR.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int N_IN     = 7,
    parameter int PIPE_LAT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] vec,
    input  logic            ref_out,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   mismatch_cnt,
    output logic [N_IN:0]   ones_cnt,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_vld,
    output logic [15:0]     signature
);

    localparam int              TW       = N_IN + 1;
    localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] VEC_ONE  = {{(N_IN-1){1'b0}}, 1'b1};
    localparam logic [N_IN:0]   CNT_ONE  = {{N_IN{1'b0}}, 1'b1};

    state_t          state_r, state_nxt_s;
    logic [N_IN-1:0] vec_r, vec_nxt_s;
    logic            busy_r, done_r, pass_r, pass_nxt_s;
    logic [N_IN:0]   mm_r, mm_nxt_s, ones_r, ones_nxt_s;
    logic [N_IN-1:0] ffv_r, ffv_nxt_s;
    logic            ffvld_r, ffvld_nxt_s;
    logic [15:0]     sig_r, sig_nxt_s;

    logic            in_run_s, start_go_s, abort_go_s;
    logic [TW-1:0]   tag_in_s, tag_out_s;
    logic            smp_vld_s, last_smp_s;
    logic [N_IN-1:0] smp_vec_s;

    assign in_run_s   = (state_r == SWEEP) || (state_r == DRAIN);
    assign start_go_s = start && !in_run_s;
    assign abort_go_s = abort && in_run_s;

    // A tag is launched for each vector actually driven in SWEEP.
    assign tag_in_s = {(state_r == SWEEP), vec_r};

    tag_delay #(
        .DEPTH (PIPE_LAT),
        .WIDTH (TW)
    ) u_tag_delay (
        .clk   (clk),
        .rst   (rst),
        .flush (abort_go_s),
        .d     (tag_in_s),
        .q     (tag_out_s)
    );

    // Samples landing on the abort edge still count; after a flush none remain.
    assign smp_vld_s  = tag_out_s[N_IN] && in_run_s;
    assign smp_vec_s  = tag_out_s[N_IN-1:0];
    assign last_smp_s = smp_vld_s && (smp_vec_s == VEC_LAST);

    // Next-state logic; abort takes priority over the final transition.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) state_nxt_s = SWEEP;
                else       state_nxt_s = state_r;
            end
            SWEEP: begin
                if (abort)                  state_nxt_s = IDLE;
                else if (last_smp_s)        state_nxt_s = DONE;
                else if (vec_r == VEC_LAST) state_nxt_s = DRAIN;
                else                        state_nxt_s = SWEEP;
            end
            DRAIN: begin
                if (abort)           state_nxt_s = IDLE;
                else if (last_smp_s) state_nxt_s = DONE;
                else                 state_nxt_s = DRAIN;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Vector generator: restart at zero, step through SWEEP, hold at the end.
    always_comb begin
        vec_nxt_s = vec_r;
        if (start_go_s) begin
            vec_nxt_s = {N_IN{1'b0}};
        end else if ((state_r == SWEEP) && !abort && (vec_r != VEC_LAST)) begin
            vec_nxt_s = vec_r + VEC_ONE;
        end else begin
            vec_nxt_s = vec_r;
        end
    end

    // Result accumulation on each valid sample; cleared by an accepted start.
    always_comb begin
        mm_nxt_s    = mm_r;
        ones_nxt_s  = ones_r;
        ffv_nxt_s   = ffv_r;
        ffvld_nxt_s = ffvld_r;
        sig_nxt_s   = sig_r;
        if (start_go_s) begin
            mm_nxt_s    = {TW{1'b0}};
            ones_nxt_s  = {TW{1'b0}};
            ffv_nxt_s   = {N_IN{1'b0}};
            ffvld_nxt_s = 1'b0;
            sig_nxt_s   = MISR_SEED;
        end else if (smp_vld_s) begin
            ones_nxt_s = ones_r + {{N_IN{1'b0}}, ref_out};
            sig_nxt_s  = misr_step(sig_r, dut_out);
            if (ref_out != dut_out) begin
                mm_nxt_s = mm_r + CNT_ONE;
                if (!ffvld_r) begin
                    ffv_nxt_s   = smp_vec_s;
                    ffvld_nxt_s = 1'b1;
                end else begin
                    ffv_nxt_s   = ffv_r;
                    ffvld_nxt_s = ffvld_r;
                end
            end else begin
                mm_nxt_s = mm_r;
            end
        end else begin
            sig_nxt_s = sig_r;
        end
    end

    // Verdict is taken on entry to DONE, including the final sample.
    always_comb begin
        pass_nxt_s = pass_r;
        if (start_go_s) begin
            pass_nxt_s = 1'b0;
        end else if ((state_nxt_s == DONE) && (state_r != DONE)) begin
            pass_nxt_s = (mm_nxt_s == {TW{1'b0}});
        end else begin
            pass_nxt_s = pass_r;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            vec_r   <= {N_IN{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            mm_r    <= {TW{1'b0}};
            ones_r  <= {TW{1'b0}};
            ffv_r   <= {N_IN{1'b0}};
            ffvld_r <= 1'b0;
            sig_r   <= MISR_SEED;
        end else begin
            state_r <= state_nxt_s;
            vec_r   <= vec_nxt_s;
            busy_r  <= (state_nxt_s == SWEEP) || (state_nxt_s == DRAIN);
            done_r  <= (state_nxt_s == DONE);
            pass_r  <= pass_nxt_s;
            mm_r    <= mm_nxt_s;
            ones_r  <= ones_nxt_s;
            ffv_r   <= ffv_nxt_s;
            ffvld_r <= ffvld_nxt_s;
            sig_r   <= sig_nxt_s;
        end
    end

    assign vec            = vec_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign mismatch_cnt   = mm_r;
    assign ones_cnt       = ones_r;
    assign first_fail_vec = ffv_r;
    assign first_fail_vld = ffvld_r;
    assign signature      = sig_r;

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencer that exhaustively exercises a combinational Boolean function-under-test pair, such as a minterm-form and a simplified-form implementation of the same 7-input function.
- Drives every input vector 0..2^N_IN-1 in ascending order to both instances and compares their outputs.
- Counts mismatches and ones, records the first failing vector, and compacts the DUT output stream into a 16-bit MISR signature.
- Sits between the lab board start/abort controls and the function instances; one sweep per start.

Parameters:
N_IN, 7, number of function inputs; sweep length 2^N_IN; legal 2..10
PIPE_LAT, 0, cycles from vec driven to ref_out/dut_out valid; legal 0..4

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  pulse; begins sweep when in IDLE or DONE
abort  in  1  pulse; terminates sweep in SWEEP/DRAIN
vec  out  N_IN  input vector driven to both function instances
ref_out  in  1  golden (minterm-form) function output
dut_out  in  1  implementation (simplified-form) function output
busy  out  1  high in SWEEP and DRAIN
done  out  1  level; high in DONE until next start
pass  out  1  valid when done; 1 iff mismatch_cnt==0
mismatch_cnt  out  N_IN+1  count of vectors where ref_out!=dut_out
ones_cnt  out  N_IN+1  count of vectors where ref_out==1
first_fail_vec  out  N_IN  lowest vector with mismatch
first_fail_vld  out  1  first_fail_vec holds a captured value
signature  out  16  MISR over dut_out stream

Behaviour:
- Reset (async, any state): state=IDLE; vec=0, busy=0, done=0, pass=0, mismatch_cnt=0, ones_cnt=0, first_fail_vec=0, first_fail_vld=0, signature=16'hFFFF; delay line valid bits cleared.
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE/DONE + start: clear counters, first_fail_*, done, pass; signature=16'hFFFF; vec=0; go to SWEEP. start is ignored in SWEEP/DRAIN.
- SWEEP: one vector per cycle. vec increments each cycle. When vec==2^N_IN-1 is driven, the next state is DRAIN and vec holds its value.
- Tag pipeline: vector index plus valid bit delayed PIPE_LAT stages. Response for the vector driven in cycle t is sampled at the edge ending cycle t+PIPE_LAT; PIPE_LAT=0 samples in the same cycle.
- On each valid sample:
  - ones_cnt += ref_out.
  - If ref_out!=dut_out: mismatch_cnt += 1. If first_fail_vld==0, capture the tag vector and set first_fail_vld.
  - signature = {sig[14:0],1'b0} ^ ((sig[15]^dut_out) ? 16'h1021 : 16'h0000).
- DRAIN: stay PIPE_LAT cycles (zero cycles when PIPE_LAT=0: go straight to DONE), until the last tagged sample is taken. Then go to DONE; done=1, pass=(mismatch_cnt==0).
- Latency: start-sampling edge to done high = 2^N_IN + PIPE_LAT + 1 rising edges.
- Counter width N_IN+1 holds the full-sweep maximum 2^N_IN without wrap.
- abort in SWEEP/DRAIN: go to IDLE next edge; flush tag pipeline; busy=0, done=0. Partial counters and signature hold their values. abort has priority over the same-cycle final transition. abort in IDLE/DONE is ignored.
- start and abort in the same cycle in IDLE/DONE: start wins, since abort is ignored there.
- vec is registered; no combinational path from inputs to any output.

Decomposition:
- Package truth_table_sweeper_pkg holds:
  - state enum {IDLE, SWEEP, DRAIN, DONE}
  - MISR_POLY=16'h1021
  - MISR_SEED=16'hFFFF
- Sub-module tag_delay: parameterized depth (PIPE_LAT), width N_IN+1 (vector+valid), async clear and synchronous flush; pass-through when depth is 0.

Test Plan:
- ref_out and dut_out both tied to vec[0]^vec[3], N_IN=7, PIPE_LAT=0 -> done after 129 edges; mismatch_cnt=0, pass=1, ones_cnt=64, first_fail_vld=0.
- ref_out=&vec, dut_out=0 -> mismatch_cnt=1, first_fail_vec=127, ones_cnt=1, pass=0.
- ref_out=vec[0], dut_out=0, PIPE_LAT=2 -> mismatch_cnt=64, first_fail_vec=1, done after 131 edges; tags aligned with delayed responses.
- abort asserted when vec=40, PIPE_LAT=0 -> IDLE next edge; busy=0, done=0; mismatch_cnt reflects vectors 0..40 only. Subsequent start gives a clean full sweep.
- start pulsed again at vec=10 -> ignored, sweep completes normally. rst asserted mid-sweep -> all outputs return to reset values immediately, without a clock edge.
- dut_out=1 constant -> signature equals reference-model MISR over 128 ones from seed 16'hFFFF; repeat sweep gives an identical signature.
